// File: rtl/msrh_l2_wr_arbiter.sv
// msrh_l2_wr_arbiter: round-robin arbiter funnelling REQ_N line-write
// requesters into a single registered L2 write slot, with a tagged command
// stream and a cap on unacknowledged L2 writes.
module msrh_l2_wr_arbiter #(
    parameter int REQ_N     = 3,
    parameter int PADDR_W   = 56,
    parameter int DATA_W    = 512,
    parameter int TAG_W     = 8,
    parameter int MAX_OUTST = 4
) (
    input  logic                           i_clk,
    input  logic                           i_reset_n,
    input  logic [REQ_N-1:0]               i_req_valid,
    output logic [REQ_N-1:0]               o_req_ready,
    input  logic [REQ_N*PADDR_W-1:0]       i_req_addr,
    input  logic [REQ_N*DATA_W-1:0]        i_req_data,
    input  logic [REQ_N*DATA_W/8-1:0]      i_req_be,
    output logic                           o_l2_valid,
    input  logic                           i_l2_ready,
    output logic [PADDR_W-1:0]             o_l2_addr,
    output logic [DATA_W-1:0]              o_l2_data,
    output logic [DATA_W/8-1:0]            o_l2_be,
    output logic [TAG_W-1:0]               o_l2_tag,
    input  logic                           i_l2_resp_valid,
    output logic [$clog2(MAX_OUTST):0]     o_outstanding,
    output logic                           o_resp_err
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MAX_OUTST) + 1;
    localparam int SEQ_W = TAG_W - 2;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_e;

    slot_e              slot_q, slot_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic [PADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [BE_W-1:0]    be_q, be_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [SEQ_W-1:0]   seq_q [4];
    logic [SEQ_W-1:0]   seq_d [4];
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic [3:0]         valid_pad;
    logic [1:0]         cand;
    logic [1:0]         win_idx;
    logic               win_vld;
    logic               below_max;
    logic               drain;
    logic               slot_free;
    logic               grant;

    // Outstanding count: +1 per accepted write, -1 per ack, never below zero.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                 input logic inc, input logic dec);
        if (inc && !dec)
            return c + CNT_W'(1);
        else if (!inc && dec && (c != '0))
            return c - CNT_W'(1);
        else
            return c;
    endfunction

    // Slot drain/free conditions and the round-robin winner search from rr_ptr.
    always_comb begin
        valid_pad = 4'(i_req_valid);
        below_max = cnt_q < CNT_W'(MAX_OUTST);
        // A full slot only leaves once L2 is ready and there is room to track it.
        drain     = (slot_q == SLOT_FULL) && i_l2_ready && below_max;
        slot_free = (slot_q == SLOT_EMPTY) || drain;
        win_vld   = 1'b0;
        win_idx   = 2'd0;
        cand      = 2'd0;
        for (int k = 0; k < REQ_N; k++) begin
            cand = 2'((int'(rr_ptr_q) + k) % REQ_N);
            if (!win_vld && valid_pad[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
        // Gated by reset so no requester is accepted while reset is held.
        grant = win_vld && slot_free && below_max && i_reset_n;
    end

    assign o_req_ready = grant ? (REQ_N'(1) << win_idx) : '0;

    // Next-state for slot contents, tag sequences, rr pointer and counters.
    always_comb begin
        slot_d   = slot_q;
        addr_d   = addr_q;
        data_d   = data_q;
        be_d     = be_q;
        tag_d    = tag_q;
        seq_d    = seq_q;
        rr_ptr_d = rr_ptr_q;
        if (grant) begin
            slot_d           = SLOT_FULL;
            addr_d           = i_req_addr[win_idx*PADDR_W +: PADDR_W];
            data_d           = i_req_data[win_idx*DATA_W +: DATA_W];
            be_d             = i_req_be[win_idx*BE_W +: BE_W];
            tag_d            = {win_idx, seq_q[win_idx]};
            seq_d[win_idx]   = seq_q[win_idx] + SEQ_W'(1);
            rr_ptr_d         = (int'(win_idx) == REQ_N - 1) ? 2'd0 : win_idx + 2'd1;
        end else if (drain) begin
            slot_d = SLOT_EMPTY;
        end
        cnt_d = cnt_next(cnt_q, drain, i_l2_resp_valid);
        // An ack arriving with nothing outstanding (and no write accepted now) is a protocol error.
        err_d = err_q | (i_l2_resp_valid && !drain && (cnt_q == '0));
    end

    // State registers; reset clears everything so outputs read zero immediately.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            slot_q   <= SLOT_EMPTY;
            addr_q   <= '0;
            data_q   <= '0;
            be_q     <= '0;
            tag_q    <= '0;
            rr_ptr_q <= 2'd0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < 4; i++) seq_q[i] <= '0;
        end else begin
            slot_q   <= slot_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            be_q     <= be_d;
            tag_q    <= tag_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            seq_q    <= seq_d;
        end
    end

    assign o_l2_valid    = (slot_q == SLOT_FULL);
    assign o_l2_addr     = addr_q;
    assign o_l2_data     = data_q;
    assign o_l2_be       = be_q;
    assign o_l2_tag      = tag_q;
    assign o_outstanding = cnt_q;
    assign o_resp_err    = err_q;

endmodule

// File: doc/msrh_l2_wr_arbiter.md
MSRH_L2_WR_ARBITER -- requirements
Module: msrh_l2_wr_arbiter

Interface
REQ-001 SHALL have parameter REQ_N, default 3: number of write requesters, 2..4 (index 0 = L1D evict, 1 = uncached store, 2 = other).
REQ-002 SHALL have parameter PADDR_W, default 56: physical address width.
REQ-003 SHALL have parameter DATA_W, default 512: line data width; byte-enable width is DATA_W/8.
REQ-004 SHALL have parameter TAG_W, default 8: L2 command tag width.
REQ-005 SHALL have parameter MAX_OUTST, default 4: maximum unacknowledged L2 writes, power of two.
REQ-006 SHALL have ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  reset; asynchronous, active-low.
- i_req_valid  in  REQ_N  per-requester request.
- o_req_ready  out  REQ_N  per-requester accept.
- i_req_addr  in  REQ_N*PADDR_W  packed addresses.
- i_req_data  in  REQ_N*DATA_W  packed data.
- i_req_be  in  REQ_N*DATA_W/8  packed byte enables.
- o_l2_valid  out  1  L2 write request valid.
- i_l2_ready  in  1  L2 accepts.
- o_l2_addr  out  PADDR_W  address.
- o_l2_data  out  DATA_W  data.
- o_l2_be  out  DATA_W/8  byte enables.
- o_l2_tag  out  TAG_W  command tag.
- i_l2_resp_valid  in  1  one write acknowledged.
- o_outstanding  out  $clog2(MAX_OUTST)+1  unacknowledged count.
- o_resp_err  out  1  sticky: response received with zero outstanding.

Function
REQ-007 Output slot SHALL be a single register; state EMPTY (o_l2_valid=0) or FULL (o_l2_valid=1).
REQ-008 Slot SHALL be "free" when EMPTY, or FULL with i_l2_ready=1 (same-cycle drain and refill).
REQ-009 Grant SHALL be issued only when slot free and o_outstanding < MAX_OUTST (counting the drain that occurs this cycle only once it is accepted).
REQ-010 Grant SHALL be round-robin: search starts at rr_ptr; winner is the first valid index at or after rr_ptr, with modulo-REQ_N wrap.
REQ-011 o_req_ready[i] SHALL be 1 only for the granted index i and only in a cycle where i_req_valid[i]=1; all other bits 0. At most one bit SHALL be set.
REQ-012 On grant of i, rr_ptr SHALL become (i+1) mod REQ_N next cycle; otherwise rr_ptr SHALL hold.
REQ-013 On grant, the slot SHALL load addr/data/be of requester i and go FULL next cycle: request-to-L2 latency is exactly 1 cycle.
REQ-014 While FULL and i_l2_ready=0, all o_l2_* SHALL hold stable.
REQ-015 FULL with i_l2_ready=1 and no grant SHALL go EMPTY next cycle.
REQ-016 o_l2_tag SHALL be {2-bit source index, (TAG_W-2)-bit per-source sequence}.
- The per-source sequence starts at 0 and increments, with wrap, on each grant to that source.
REQ-017 o_outstanding SHALL increment on o_l2_valid&i_l2_ready and decrement on i_l2_resp_valid.
- Both in the same cycle: unchanged.
- Response at count 0: count stays 0 and o_resp_err sets (cleared only by reset).
REQ-018 With o_outstanding==MAX_OUTST, no grant SHALL be issued, but the FULL slot SHALL still present and may drain only when count < MAX_OUTST.
- o_l2_valid holds while stalled.

Reset
REQ-019 On asynchronous reset assertion, all outputs SHALL be 0 immediately and SHALL remain 0 while reset is held:
- o_l2_valid, o_req_ready, o_l2_addr/data/be/tag, o_outstanding, o_resp_err.
- rr_ptr=0; all sequence counters=0.
REQ-020 Reset asserted mid-operation SHALL discard a FULL slot without presenting it; the first grant after deassertion SHALL go to the lowest valid index.

Verification
REQ-021 All three requesters valid continuously, i_l2_ready=1, responses each cycle:
- grants SHALL follow 0,1,2,0,1,2.
- tags SHALL be 0x00, 0x40, 0x80, 0x01, …
REQ-022 Req 0 granted, i_l2_ready=0 for 5 cycles:
- o_l2_* SHALL stay constant.
- no o_req_ready SHALL assert.
- on ready, the slot drains and a waiting req 1 is granted in the same cycle, appearing on o_l2 the next cycle.
REQ-023 No responses, i_l2_ready=1, 6 back-to-back requests from req 1:
- exactly 4 SHALL issue.
- o_outstanding SHALL reach 4, 5th stays in the slot stalled.
- one i_l2_resp_valid SHALL release it.
REQ-024 Same-cycle L2 accept and response at count 2 -> count SHALL remain 2.
REQ-025 i_l2_resp_valid at count 0 -> o_resp_err=1 and count SHALL remain 0.
REQ-026 Reset pulsed while FULL -> o_l2_valid=0 during reset; afterwards, with reqs 1 and 2 valid, the first grant SHALL go to req 1.
